// File: rtl/jtdd_romsched_pkg.sv
// jtdd_romsched_pkg
//   Shared definitions for the ROM read scheduler: default slot count,
//   SDRAM address/data widths and the scheduler FSM state encoding.
//   No ports (package).
package jtdd_romsched_pkg;

   localparam int DEF_SLOTS = 8;
   localparam int DEF_AW    = 22;
   localparam int DEF_DW    = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // looking for a missing slot
      ST_REQ  = 2'd1,   // sdram_req held until the controller acks
      ST_WAIT = 2'd2    // request accepted, waiting for our read data
   } state_t;

endpackage

// File: rtl/jtdd_rr_pick.sv
// jtdd_rr_pick
//   Combinational round-robin priority encoder. Returns the first set bit
//   of miss found when scanning from index ptr upward, wrapping at SLOTS.
// Ports:
//   miss  in   SLOTS  per-slot request vector
//   ptr   in   PW     scan start index
//   gnt   out  PW     selected index (0 when nothing is requested)
//   any   out  1      at least one request present
module jtdd_rr_pick #(
   parameter int SLOTS = 8,
   parameter int PW    = $clog2(SLOTS)
) (
   input  logic [SLOTS-1:0] miss,
   input  logic [PW-1:0]    ptr,
   output logic [PW-1:0]    gnt,
   output logic             any
);

   logic [PW-1:0] idx;

   // Scan from the farthest offset down to offset 0 so that the entry
   // closest to ptr is the last one written and therefore wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = SLOTS - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr) + k) % SLOTS);
         if (miss[idx]) gnt = idx;
      end
   end

   assign any = |miss;

endmodule

// File: rtl/jtdd_romsched.sv
// jtdd_romsched
//   Shares the single SDRAM read port between SLOTS ROM requesters. Each
//   slot keeps a one-word cache (valid/tag/data); a slot whose request does
//   not hit its cache is a miss, misses are granted round-robin and served
//   one at a time through the SDRAM req/ack/ready handshake.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   slot_cs       per-slot read request (level)
//   slot_addr     per-slot word address, slot i at [i*AW +: AW]
//   slot_ok       per-slot: cached word matches the current address
//   slot_dout     per-slot cached word, slot i at [i*DW +: DW]
//   downloading   ROM download in progress: abort and invalidate everything
//   sdram_req     read request, held until sdram_ack
//   sdram_addr    read address, stable while sdram_req
//   sdram_ack     one-cycle pulse, request accepted
//   data_rdy      one-cycle pulse, read data valid
//   data_dst      qualifies data_rdy as belonging to this block
//   data_read     read data
module jtdd_romsched
   import jtdd_romsched_pkg::*;
#(
   parameter int SLOTS = DEF_SLOTS,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SLOTS-1:0]    slot_cs,
   input  logic [SLOTS*AW-1:0] slot_addr,
   output logic [SLOTS-1:0]    slot_ok,
   output logic [SLOTS*DW-1:0] slot_dout,
   input  logic                downloading,
   output logic                sdram_req,
   output logic [AW-1:0]       sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic                data_dst,
   input  logic [DW-1:0]       data_read
);

   localparam int PW = $clog2(SLOTS);

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [PW-1:0] gnt_q, gnt_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          fill;

   logic [SLOTS-1:0] miss;
   logic [AW-1:0]    addr_a [SLOTS];
   logic [PW-1:0]    pick;
   logic             any;

   jtdd_rr_pick #(.SLOTS(SLOTS), .PW(PW)) u_pick (
      .miss (miss),
      .ptr  (ptr_q),
      .gnt  (pick),
      .any  (any)
   );

   // Per-slot one-word cache. The tag stored on a fill is the address that
   // was sent to SDRAM, so a requester that moved mid-flight still misses.
   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      logic          valid_q;
      logic [AW-1:0] tag_q;
      logic [DW-1:0] data_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
         end else if (downloading) begin
            valid_q <= 1'b0;
         end else if (fill && gnt_q == PW'(i)) begin
            valid_q <= 1'b1;
            tag_q   <= addr_q;
            data_q  <= data_read;
         end
      end

      assign addr_a[i]              = slot_addr[i*AW +: AW];
      assign slot_ok[i]             = slot_cs[i] & valid_q & (tag_q == addr_a[i]);
      assign miss[i]                = slot_cs[i] & ~slot_ok[i] & ~downloading;
      assign slot_dout[i*DW +: DW]  = data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         gnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      fill    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any) begin
               gnt_d   = pick;
               addr_d  = addr_a[pick];
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (sdram_ack) begin
               req_d   = 1'b0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Unqualified data_rdy belongs to another client of the controller.
            if (data_rdy && data_dst) begin
               fill    = 1'b1;
               ptr_d   = (gnt_q == PW'(SLOTS - 1)) ? '0 : gnt_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      // A download invalidates the ROM contents; drop any transfer in flight.
      if (downloading) begin
         state_d = ST_IDLE;
         req_d   = 1'b0;
         fill    = 1'b0;
      end
   end

   assign sdram_req  = req_q;
   assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jtdd_romsched.sv
module tb_jtdd_romsched;

   localparam int N  = 8;
   localparam int AW = 22;
   localparam int DW = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      slot_cs;
   logic [N*AW-1:0]   slot_addr;
   logic [N-1:0]      slot_ok;
   logic [N*DW-1:0]   slot_dout;
   logic              downloading;
   logic              sdram_req;
   logic [AW-1:0]     sdram_addr;
   logic              sdram_ack;
   logic              data_rdy;
   logic              data_dst;
   logic [DW-1:0]     data_read;

   int total = 0;
   int bad   = 0;

   jtdd_romsched #(.SLOTS(N), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .slot_cs(slot_cs), .slot_addr(slot_addr),
      .slot_ok(slot_ok), .slot_dout(slot_dout), .downloading(downloading),
      .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
      .data_rdy(data_rdy), .data_dst(data_dst), .data_read(data_read)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: per-slot cache + rr pointer ----------
   bit            m_valid [N];
   logic [AW-1:0] m_tag   [N];
   logic [DW-1:0] m_data  [N];
   int            m_ptr;

   function automatic logic [AW-1:0] addr_of(int i);
      return slot_addr[i*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] dout_of(int i);
      return slot_dout[i*DW +: DW];
   endfunction

   function automatic logic [N-1:0] m_ok_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++)
         v[i] = slot_cs[i] && m_valid[i] && (m_tag[i] == addr_of(i));
      return v;
   endfunction

   function automatic logic [N*DW-1:0] m_dout_vec();
      logic [N*DW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = m_data[i];
      return v;
   endfunction

   // Slot the scheduler must serve next, or -1 when nothing misses.
   function automatic int m_grant();
      logic [N-1:0] ok;
      int j;
      if (downloading) return -1;
      ok = m_ok_vec();
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (slot_cs[j] && !ok[j]) return j;
      end
      return -1;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0; m_tag[i] = '0; m_data[i] = '0;
      end
      m_ptr = 0;
   endtask

   task automatic m_fill(int g, logic [AW-1:0] a, logic [DW-1:0] d);
      m_valid[g] = 1; m_tag[g] = a; m_data[g] = d;
      m_ptr = (g + 1) % N;
   endtask

   // ---------------- stimulus helpers (no checking) ------------------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_addr(int i, logic [AW-1:0] a);
      slot_addr[i*AW +: AW] = a;
   endtask

   task automatic wait_req(input int maxc, output int lat);
      lat = -1;
      for (int c = 1; c <= maxc; c++) begin
         tick();
         if (sdram_req === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic pulse_ack(int delay);
      repeat (delay) tick();
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
   endtask

   task automatic pulse_rdy(int delay, logic [DW-1:0] d, logic dst);
      repeat (delay) tick();
      data_rdy = 1'b1; data_dst = dst; data_read = d;
      tick();
      data_rdy = 1'b0; data_dst = 1'b0;
   endtask

   // ---------------- scenarios ----------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0; slot_cs = '0; slot_addr = '0; downloading = 1'b0;
      sdram_ack = 1'b0; data_rdy = 1'b0; data_dst = 1'b0; data_read = '0;
      m_reset();
      repeat (3) tick();
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", sdram_req); end
      total++; if (sdram_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", sdram_addr); end
      total++; if (slot_dout !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", slot_dout); end
      slot_cs = 8'hFF;
      #1;
      total++; if (slot_ok !== '0) begin bad++; $display("FAIL reset_ok: got %b want 0", slot_ok); end
      slot_cs = '0;
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL idle_no_req: got %b want 0", sdram_req); end
   endtask

   task automatic test_single();
      int lat, reqs, drops;
      slot_cs = 8'b0000_0100;
      set_addr(2, 22'h00100);
      wait_req(1, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL single_latency: got %0d want 1", lat); end
      total++; if (sdram_addr !== 22'h00100) begin bad++; $display("FAIL single_addr: got %h want 00100", sdram_addr); end
      repeat (3) tick();
      total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL single_req_held: got %b want 1", sdram_req); end
      pulse_ack(0);
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL single_req_drop: got %b want 0", sdram_req); end
      pulse_rdy(4, 16'hBEEF, 1'b1);
      m_fill(2, 22'h00100, 16'hBEEF);
      total++; if (slot_ok !== 8'b0000_0100) begin bad++; $display("FAIL single_ok: got %b want 00000100", slot_ok); end
      total++; if (dout_of(2) !== 16'hBEEF) begin bad++; $display("FAIL single_dout: got %h want beef", dout_of(2)); end
      reqs = 0; drops = 0;
      repeat (100) begin
         tick();
         if (sdram_req) reqs++;
         if (!slot_ok[2]) drops++;
      end
      total++; if (reqs !== 0) begin bad++; $display("FAIL hit_no_traffic: got %0d req cycles want 0", reqs); end
      total++; if (drops !== 0) begin bad++; $display("FAIL hit_ok_steady: got %0d low cycles want 0", drops); end
   endtask

   task automatic test_reset_midwait();
      int lat;
      slot_cs = 8'b0000_1100;
      set_addr(3, 22'h00200);
      wait_req(1, lat);
      pulse_ack(1);
      total++; if (slot_ok[2] !== 1'b1) begin bad++; $display("FAIL pre_reset_ok2: got %b want 1", slot_ok[2]); end
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL midwait_reset_req: got %b want 0", sdram_req); end
      total++; if (slot_ok !== '0) begin bad++; $display("FAIL midwait_reset_ok: got %b want 0", slot_ok); end
      total++; if (slot_dout !== '0) begin bad++; $display("FAIL midwait_reset_dout: got %h want 0", slot_dout); end
      slot_cs = '0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_all_slots();
      int lat;
      logic [DW-1:0] d;
      for (int i = 0; i < N; i++) set_addr(i, 22'h01000 + 22'(i * 'h11));
      slot_cs = 8'hFF;
      for (int k = 0; k < N; k++) begin
         wait_req(1, lat);
         total++; if (lat !== 1) begin bad++; $display("FAIL all_latency[%0d]: got %0d want 1", k, lat); end
         total++; if (sdram_addr !== addr_of(k)) begin bad++; $display("FAIL all_order[%0d]: got %h want %h", k, sdram_addr, addr_of(k)); end
         d = DW'($urandom);
         pulse_ack($urandom_range(0, 3));
         pulse_rdy($urandom_range(0, 4), d, 1'b1);
         m_fill(k, addr_of(k), d);
      end
      total++; if (slot_ok !== 8'hFF) begin bad++; $display("FAIL all_ok: got %b want ff", slot_ok); end
      total++; if (slot_dout !== m_dout_vec()) begin bad++; $display("FAIL all_dout: got %h want %h", slot_dout, m_dout_vec()); end
      // pointer sits at 0 after slot 7; move it with slot 5, then 0 and 4 race
      set_addr(5, 22'h03005);
      wait_req(1, lat);
      total++; if (sdram_addr !== 22'h03005) begin bad++; $display("FAIL remiss5_addr: got %h want 03005", sdram_addr); end
      d = DW'($urandom);
      pulse_ack(1); pulse_rdy(1, d, 1'b1);
      m_fill(5, 22'h03005, d);
      set_addr(0, 22'h03000);
      set_addr(4, 22'h03004);
      for (int k = 0; k < 2; k++) begin
         int g;
         g = m_grant();
         wait_req(1, lat);
         total++; if (sdram_addr !== (k == 0 ? 22'h03000 : 22'h03004)) begin bad++; $display("FAIL wrap_order[%0d]: got %h want %h", k, sdram_addr, (k == 0 ? 22'h03000 : 22'h03004)); end
         d = DW'($urandom);
         pulse_ack(0); pulse_rdy(2, d, 1'b1);
         m_fill(g, addr_of(g), d);
      end
      total++; if (slot_dout !== m_dout_vec()) begin bad++; $display("FAIL wrap_dout: got %h want %h", slot_dout, m_dout_vec()); end
   endtask

   task automatic test_addr_change();
      int lat;
      logic [DW-1:0] d;
      slot_cs = 8'b0000_0010;
      set_addr(1, 22'h00010);
      wait_req(1, lat);
      total++; if (sdram_addr !== 22'h00010) begin bad++; $display("FAIL move_addr1: got %h want 00010", sdram_addr); end
      pulse_ack(1);
      set_addr(1, 22'h00011);
      d = 16'h5A5A;
      pulse_rdy(2, d, 1'b1);
      m_fill(1, 22'h00010, d);
      total++; if (slot_ok[1] !== 1'b0) begin bad++; $display("FAIL move_ok_low: got %b want 0", slot_ok[1]); end
      total++; if (dout_of(1) !== 16'h5A5A) begin bad++; $display("FAIL move_cached: got %h want 5a5a", dout_of(1)); end
      wait_req(1, lat);
      total++; if (sdram_addr !== 22'h00011) begin bad++; $display("FAIL move_reissue: got %h (lat %0d) want 00011", sdram_addr, lat); end
      pulse_ack(0); pulse_rdy(0, 16'h1111, 1'b1);
      m_fill(1, 22'h00011, 16'h1111);
      total++; if (slot_ok !== m_ok_vec()) begin bad++; $display("FAIL move_final_ok: got %b want %b", slot_ok, m_ok_vec()); end
   endtask

   task automatic test_dst();
      int lat;
      slot_cs = 8'b0100_0000;
      set_addr(6, 22'h00777);
      wait_req(1, lat);
      pulse_ack(0);
      pulse_rdy(1, 16'hDEAD, 1'b0);
      repeat (2) tick();
      total++; if (slot_ok[6] !== 1'b0) begin bad++; $display("FAIL dst_ignored_ok: got %b want 0", slot_ok[6]); end
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL dst_still_wait: got req %b want 0", sdram_req); end
      pulse_rdy(0, 16'h1234, 1'b1);
      m_fill(6, 22'h00777, 16'h1234);
      total++; if (dout_of(6) !== 16'h1234) begin bad++; $display("FAIL dst_fill: got %h want 1234", dout_of(6)); end
      // a qualified pulse while idle must not touch any cache
      pulse_rdy(0, 16'hFFFF, 1'b1);
      tick();
      total++; if (slot_dout !== m_dout_vec()) begin bad++; $display("FAIL idle_rdy_ignored: got %h want %h", slot_dout, m_dout_vec()); end
      total++; if (slot_ok !== m_ok_vec()) begin bad++; $display("FAIL idle_rdy_ok: got %b want %b", slot_ok, m_ok_vec()); end
   endtask

   task automatic test_download();
      int lat, reqs, oks, g;
      logic [DW-1:0] d;
      slot_cs = 8'b0100_0100;
      set_addr(2, 22'h00222);
      wait_req(1, lat);
      total++; if (slot_ok[6] !== 1'b1) begin bad++; $display("FAIL dl_pre_ok6: got %b want 1", slot_ok[6]); end
      downloading = 1'b1;
      tick();
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL dl_req_drop: got %b want 0", sdram_req); end
      total++; if (slot_ok !== '0) begin bad++; $display("FAIL dl_valid_clr: got %b want 0", slot_ok); end
      reqs = 0; oks = 0;
      for (int c = 0; c < 20; c++) begin
         sdram_ack = (c == 3); data_rdy = (c == 8); data_dst = (c == 8); data_read = 16'hBAD0;
         tick();
         if (sdram_req) reqs++;
         if (slot_ok != 0) oks++;
      end
      sdram_ack = 1'b0; data_rdy = 1'b0; data_dst = 1'b0;
      total++; if (reqs !== 0) begin bad++; $display("FAIL dl_no_req: got %0d req cycles want 0", reqs); end
      total++; if (oks !== 0) begin bad++; $display("FAIL dl_no_ok: got %0d ok cycles want 0", oks); end
      downloading = 1'b0;
      for (int k = 0; k < N; k++) begin
         g = m_grant();
         if (g < 0) break;
         wait_req(1, lat);
         total++; if (lat !== 1 || sdram_addr !== addr_of(g)) begin bad++; $display("FAIL dl_resume[%0d]: got %h lat %0d want %h", k, sdram_addr, lat, addr_of(g)); end
         d = DW'($urandom);
         pulse_ack($urandom_range(0, 2)); pulse_rdy($urandom_range(0, 2), d, 1'b1);
         m_fill(g, sdram_addr, d);
      end
      total++; if (slot_ok !== 8'b0100_0100) begin bad++; $display("FAIL dl_refill_ok: got %b want 01000100", slot_ok); end
      total++; if (slot_dout !== m_dout_vec()) begin bad++; $display("FAIL dl_refill_dout: got %h want %h", slot_dout, m_dout_vec()); end
   endtask

   task automatic test_back_to_back();
      int lat, g;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int r = 0; r < 40; r++) begin
         slot_cs = N'($urandom);
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 2) == 0) set_addr(i, 22'h00040 + 22'($urandom_range(0, 3)));
         for (int k = 0; k < N + 1; k++) begin
            g = m_grant();
            if (g < 0) break;
            wait_req(1, lat);
            total++; if (lat !== 1 || sdram_addr !== addr_of(g)) begin bad++; $display("FAIL b2b_grant[%0d.%0d]: got %h lat %0d want %h", r, k, sdram_addr, lat, addr_of(g)); end
            a = sdram_addr;
            d = DW'($urandom);
            pulse_ack($urandom_range(0, 3));
            pulse_rdy($urandom_range(0, 3), d, 1'b1);
            m_fill(g, a, d);
         end
         tick();
         total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL b2b_quiet[%0d]: got %b want 0", r, sdram_req); end
         total++; if (slot_ok !== m_ok_vec() || slot_dout !== m_dout_vec()) begin bad++; $display("FAIL b2b_cache[%0d]: ok %b dout %h want ok %b dout %h", r, slot_ok, slot_dout, m_ok_vec(), m_dout_vec()); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_reset_midwait();
      test_all_slots();
      test_addr_change();
      test_dst();
      test_download();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
